jzjpcc_decode_execute_skid: RTL and testbench

- Parametrised decode→execute pipeline register.
- Generalises the fixed single-register decode output with:
  - valid/ready handshaking on both sides;
  - a 2-entry skid buffer, so stalls do not combinationally propagate back into decode;
  - flush-to-bubble;
  - writeback bypass that keeps held rs1/rs2 operands current while stalled.
- Sits between decode logic and the execute stage.

---
 rtl/jzjpcc_decode_execute_skid.sv | 179 +++++++++++++++++
 tb/tb_jzjpcc_decode_execute_skid.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_decode_execute_skid.sv
// rtl/jzjpcc_decode_execute_skid.sv - decode->execute pipeline register with 2-entry skid, flush and writeback bypass (optional perf counters: JZJPCC_DECODE_EXECUTE_PERF_EN)
module jzjpcc_decode_execute_skid #(
  parameter int PC_MAX_B = 31,
  parameter int XLEN     = 32,
  parameter int CTRL_W   = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_decValid,
  output logic                o_decReady,
  input  logic [CTRL_W-1:0]   i_decControl,
  input  logic [4:0]          i_decRs1Addr,
  input  logic [4:0]          i_decRs2Addr,
  input  logic [XLEN-1:0]     i_decRs1,
  input  logic [XLEN-1:0]     i_decRs2,
  input  logic [XLEN-1:0]     i_decImmediate,
  input  logic [PC_MAX_B:2]   i_decCurrentPC,
  input  logic [4:0]          i_decRdAddr,
  input  logic [2:0]          i_decFunct3,
  input  logic                i_wbWriteEnable,
  input  logic [4:0]          i_wbRdAddr,
  input  logic [XLEN-1:0]     i_wbRdData,
  input  logic                i_flush,
  output logic                o_exeValid,
  input  logic                i_exeReady,
  output logic [CTRL_W-1:0]   o_exeControl,
  output logic [4:0]          o_exeRs1Addr,
  output logic [4:0]          o_exeRs2Addr,
  output logic [XLEN-1:0]     o_exeRs1,
  output logic [XLEN-1:0]     o_exeRs2,
  output logic [XLEN-1:0]     o_exeImmediate,
  output logic [PC_MAX_B:2]   o_exeCurrentPC,
  output logic [4:0]          o_exeRdAddr,
  output logic [2:0]          o_exeFunct3
`ifdef JZJPCC_DECODE_EXECUTE_PERF_EN
  ,
  output logic [31:0]         o_perfStallCycles,
  output logic [31:0]         o_perfBubbles
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [4:0]         rs1a;
    logic [4:0]         rs2a;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [XLEN-1:0]    imm;
    logic [PC_MAX_B:2]  pc;
    logic [4:0]         rd;
    logic [2:0]         f3;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_exeValid;
  logic   r_decReady;
  entry_t r_main;
  entry_t r_skid;

  entry_t w_decEntry;
  entry_t w_mainByp;
  entry_t w_skidByp;
  logic   w_acc;
  logic   w_pop;

  // Replace a source operand with the value being written back this cycle; x0 is hardwired and never forwarded
  function automatic entry_t bypass(input entry_t e, input logic wb_en,
                                    input logic [4:0] wb_addr, input logic [XLEN-1:0] wb_data);
    entry_t r;
    r = e;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == e.rs1a)) r.rs1 = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == e.rs2a)) r.rs2 = wb_data;
    return r;
  endfunction

  // Bypassed views of the incoming payload and of both held entries
  always_comb begin
    w_decEntry = '{ctrl: i_decControl, rs1a: i_decRs1Addr, rs2a: i_decRs2Addr,
                   rs1: i_decRs1, rs2: i_decRs2, imm: i_decImmediate,
                   pc: i_decCurrentPC, rd: i_decRdAddr, f3: i_decFunct3};
    w_decEntry = bypass(w_decEntry, i_wbWriteEnable, i_wbRdAddr, i_wbRdData);
    w_mainByp  = bypass(r_main, i_wbWriteEnable, i_wbRdAddr, i_wbRdData);
    w_skidByp  = bypass(r_skid, i_wbWriteEnable, i_wbRdAddr, i_wbRdData);
  end

  assign w_acc = i_decValid & r_decReady;
  assign w_pop = r_exeValid & i_exeReady;

  // Skid FSM: decReady depends only on next state, so exeReady never reaches decode combinationally
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= S_EMPTY;
      r_exeValid <= 1'b0;
      r_decReady <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (i_flush) begin
      r_state        <= S_EMPTY;
      r_exeValid     <= 1'b0;
      r_decReady     <= 1'b1;
      r_main.ctrl[0] <= 1'b0;
      r_main.rd      <= 5'd0;
    end else begin
      r_main <= w_mainByp;
      r_skid <= w_skidByp;
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_main     <= w_decEntry;
            r_state    <= S_ONE;
            r_exeValid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && !w_pop) begin
            r_skid     <= w_decEntry;
            r_state    <= S_TWO;
            r_decReady <= 1'b0;
          end else if (w_acc && w_pop) begin
            r_main <= w_decEntry;
          end else if (w_pop) begin
            r_state    <= S_EMPTY;
            r_exeValid <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main     <= w_skidByp;
            r_state    <= S_ONE;
            r_decReady <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_exeValid <= 1'b0;
          r_decReady <= 1'b1;
        end
      endcase
    end
  end

  assign o_decReady     = r_decReady;
  assign o_exeValid     = r_exeValid;
  assign o_exeControl   = r_main.ctrl;
  assign o_exeRs1Addr   = r_main.rs1a;
  assign o_exeRs2Addr   = r_main.rs2a;
  assign o_exeRs1       = r_main.rs1;
  assign o_exeRs2       = r_main.rs2;
  assign o_exeImmediate = r_main.imm;
  assign o_exeCurrentPC = r_main.pc;
  assign o_exeRdAddr    = r_main.rd;
  assign o_exeFunct3    = r_main.f3;

`ifdef JZJPCC_DECODE_EXECUTE_PERF_EN
  logic [31:0] r_perfStallCycles;
  logic [31:0] r_perfBubbles;

  // Stall and bubble counters, free-running and wrapping
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_perfStallCycles <= 32'd0;
      r_perfBubbles     <= 32'd0;
    end else begin
      if (r_exeValid && !i_exeReady) r_perfStallCycles <= r_perfStallCycles + 32'd1;
      if (i_flush && (r_exeValid || i_decValid)) r_perfBubbles <= r_perfBubbles + 32'd1;
    end
  end

  assign o_perfStallCycles = r_perfStallCycles;
  assign o_perfBubbles     = r_perfBubbles;
`endif

endmodule

// File: tb/tb_jzjpcc_decode_execute_skid.sv
// tb/tb_jzjpcc_decode_execute_skid.sv - table-driven bench for jzjpcc_decode_execute_skid
module tb_jzjpcc_decode_execute_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic        dr;
  logic [7:0]  dctl;
  logic [4:0]  drs1a, drs2a, drd;
  logic [31:0] drs1, drs2, dimm;
  logic [31:2] dpc;
  logic [2:0]  df3;
  logic        wbe;
  logic [4:0]  wba;
  logic [31:0] wbd;
  logic        fl;
  logic        ev;
  logic        er;
  logic [7:0]  ectl;
  logic [4:0]  ers1a, ers2a, erd;
  logic [31:0] ers1, ers2, eimm;
  logic [31:2] epc;
  logic [2:0]  ef3;
`ifdef JZJPCC_DECODE_EXECUTE_PERF_EN
  logic [31:0] pstall, pbub;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jzjpcc_decode_execute_skid dut (
    .i_clock(clk), .i_reset(rst), .i_decValid(dv), .o_decReady(dr),
    .i_decControl(dctl), .i_decRs1Addr(drs1a), .i_decRs2Addr(drs2a),
    .i_decRs1(drs1), .i_decRs2(drs2), .i_decImmediate(dimm),
    .i_decCurrentPC(dpc), .i_decRdAddr(drd), .i_decFunct3(df3),
    .i_wbWriteEnable(wbe), .i_wbRdAddr(wba), .i_wbRdData(wbd),
    .i_flush(fl), .o_exeValid(ev), .i_exeReady(er),
    .o_exeControl(ectl), .o_exeRs1Addr(ers1a), .o_exeRs2Addr(ers2a),
    .o_exeRs1(ers1), .o_exeRs2(ers2), .o_exeImmediate(eimm),
    .o_exeCurrentPC(epc), .o_exeRdAddr(erd), .o_exeFunct3(ef3)
`ifdef JZJPCC_DECODE_EXECUTE_PERF_EN
    , .o_perfStallCycles(pstall), .o_perfBubbles(pbub)
`endif
  );

  typedef struct {
    logic        rst, fl, dv, er, ctl0;
    logic [29:0] pc;
    logic [4:0]  rd, rs1a;
    logic [31:0] rs1;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        chk_pl, chk_rc;
    logic        x_ev, x_dr;
    logic [29:0] x_pc;
    logic [4:0]  x_rd;
    logic [31:0] x_rs1;
    logic        x_ctl0;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst fl dv er c0  pc     rd  rs1a rs1           wbe wba wbd           pl rc ev dr xpc    xrd xrs1          xc0
    vecs[0]  = '{0,0,1,0,1, 30'h99, 3, 5, 32'hAA,       0, 0, 32'h0,        1, 1, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[1]  = '{0,0,1,0,1, 30'h99, 3, 5, 32'hAA,       0, 0, 32'h0,        1, 1, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[2]  = '{1,0,1,0,1, 30'h10, 1, 5, 32'h100,      0, 0, 32'h0,        1, 1, 1, 1, 30'h10, 1, 32'h100,      1};
    vecs[3]  = '{1,0,1,0,1, 30'h14, 2, 6, 32'h200,      0, 0, 32'h0,        1, 1, 1, 0, 30'h10, 1, 32'h100,      1};
    vecs[4]  = '{1,0,1,0,1, 30'h18, 3, 7, 32'h300,      0, 0, 32'h0,        1, 1, 1, 0, 30'h10, 1, 32'h100,      1};
    vecs[5]  = '{1,0,1,0,1, 30'h18, 3, 7, 32'h300,      1, 5, 32'hDEADBEEF, 1, 1, 1, 0, 30'h10, 1, 32'hDEADBEEF, 1};
    vecs[6]  = '{1,0,1,0,1, 30'h18, 3, 7, 32'h300,      1, 6, 32'h6666,     1, 1, 1, 0, 30'h10, 1, 32'hDEADBEEF, 1};
    vecs[7]  = '{1,0,1,1,1, 30'h18, 3, 7, 32'h300,      0, 0, 32'h0,        1, 1, 1, 1, 30'h14, 2, 32'h6666,     1};
    vecs[8]  = '{1,0,1,1,1, 30'h18, 3, 7, 32'h300,      0, 0, 32'h0,        1, 1, 1, 1, 30'h18, 3, 32'h300,      1};
    vecs[9]  = '{1,0,0,1,1, 30'h0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[10] = '{1,0,1,0,1, 30'h20, 4, 1, 32'h400,      0, 0, 32'h0,        1, 1, 1, 1, 30'h20, 4, 32'h400,      1};
    vecs[11] = '{1,0,1,0,1, 30'h24, 5, 2, 32'h500,      0, 0, 32'h0,        1, 1, 1, 0, 30'h20, 4, 32'h400,      1};
    vecs[12] = '{1,1,1,0,1, 30'h28, 6, 2, 32'h550,      0, 0, 32'h0,        0, 1, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[13] = '{1,0,0,0,1, 30'h28, 6, 2, 32'h550,      0, 0, 32'h0,        0, 1, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[14] = '{1,0,1,1,1, 30'h30, 7, 3, 32'h600,      0, 0, 32'h0,        1, 1, 1, 1, 30'h30, 7, 32'h600,      1};
    vecs[15] = '{1,0,0,1,1, 30'h0,  0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[16] = '{1,0,1,0,1, 30'h34, 8, 4, 32'h700,      0, 0, 32'h0,        1, 1, 1, 1, 30'h34, 8, 32'h700,      1};
    vecs[17] = '{0,1,1,0,1, 30'h38, 9, 4, 32'h800,      0, 0, 32'h0,        1, 1, 0, 1, 30'h0,  0, 32'h0,        0};
    vecs[18] = '{1,1,1,0,1, 30'h3C, 9, 4, 32'h900,      0, 0, 32'h0,        0, 1, 0, 1, 30'h0,  0, 32'h0,        0};

    rst = 1'b0; fl = 1'b0; dv = 1'b0; er = 1'b0;
    dctl = 8'h0; drs1a = 5'd0; drs2a = 5'd0; drd = 5'd0;
    drs1 = 32'h0; drs2 = 32'h0; dimm = 32'h0; dpc = 30'h0; df3 = 3'd0;
    wbe = 1'b0; wba = 5'd0; wbd = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; fl = vecs[i].fl; dv = vecs[i].dv; er = vecs[i].er;
      dctl = {7'd0, vecs[i].ctl0}; dpc = vecs[i].pc; drd = vecs[i].rd;
      drs1a = vecs[i].rs1a; drs1 = vecs[i].rs1;
      wbe = vecs[i].wbe; wba = vecs[i].wba; wbd = vecs[i].wbd;
      step();
      check($sformatf("v%0d exeValid", i), {31'd0, ev}, {31'd0, vecs[i].x_ev});
      check($sformatf("v%0d decReady", i), {31'd0, dr}, {31'd0, vecs[i].x_dr});
      if (vecs[i].chk_pl) begin
        check($sformatf("v%0d exePC", i), {2'd0, epc}, {2'd0, vecs[i].x_pc});
        check($sformatf("v%0d exeRs1", i), ers1, vecs[i].x_rs1);
      end
      if (vecs[i].chk_rc) begin
        check($sformatf("v%0d exeRdAddr", i), {27'd0, erd}, {27'd0, vecs[i].x_rd});
        check($sformatf("v%0d exeCtl0", i), {31'd0, ectl[0]}, {31'd0, vecs[i].x_ctl0});
      end
    end

    // Bypass on load for rs2, and x0 on rs1 ignored at load and while held
    fl = 1'b0; dv = 1'b1; er = 1'b0; dpc = 30'h40; drd = 5'd10;
    drs1a = 5'd0; drs1 = 32'h77; drs2a = 5'd7; drs2 = 32'h1;
    wbe = 1'b1; wba = 5'd7; wbd = 32'h55;
    step();
    check("load exeValid", {31'd0, ev}, 32'd1);
    check("load bypass exeRs2", ers2, 32'h55);
    check("load exeRs1", ers1, 32'h77);
    dv = 1'b0; wba = 5'd0; wbd = 32'h1234;
    step();
    check("x0 held exeRs1", ers1, 32'h77);
    check("x0 held exeRs2", ers2, 32'h55);
    wbe = 1'b0; er = 1'b1;
    step();
    check("drain exeValid", {31'd0, ev}, 32'd0);

`ifdef JZJPCC_DECODE_EXECUTE_PERF_EN
    rst = 1'b0; er = 1'b0; dv = 1'b0;
    step();
    check("perf reset stall", pstall, 32'd0);
    check("perf reset bubbles", pbub, 32'd0);
    rst = 1'b1; dv = 1'b1;
    step();
    dv = 1'b0;
    repeat (3) step();
    fl = 1'b1; er = 1'b1;
    step();
    fl = 1'b0; er = 1'b0;
    check("perf stall", pstall, 32'd3);
    check("perf bubbles", pbub, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("perf stall after reset", pstall, 32'd0);
    check("perf bubbles after reset", pbub, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
